clk_div_monitor: RTL and testbench
==================================

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of all period/high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000: clk cycles without a detected rise before the monitor declares stall.
REQ-003 SHALL have parameter LOCK_N, default 4: consecutive in-tolerance periods required to assert lock.
REQ-004 SHALL have port clk, input, 1: single system clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port clk_in, input, 1: divided clock under test, asynchronous to clk, at most clk/4.
REQ-007 SHALL have port exp_period, input, CNT_W: expected clk_in period in clk cycles, quasi-static.
REQ-008 SHALL have port tol, input, CNT_W: allowed absolute period deviation in clk cycles.
REQ-009 SHALL have port period_out, output, CNT_W: last measured period in clk cycles.
REQ-010 SHALL have port high_out, output, CNT_W: last measured high time in clk cycles.
REQ-011 SHALL have port meas_valid, output, 1: one-cycle pulse when period_out/high_out update.
REQ-012 SHALL have port lock, output, 1: high while the state is LOCK.
REQ-013 SHALL have port stall, output, 1: high while the state is STALL.

Function
REQ-014 SHALL pass clk_in through a 2-flop synchronizer; a rise is detected when the synchronized level is 1 and the previous synchronized level was 0.
REQ-015 Latency: a rise is detected exactly 3 clk edges after clk_in rises (2 sync flops + 1 edge-detect register).
REQ-016 SHALL keep per_cnt: loads 1 on the rise cycle, then increments each cycle, saturating at all-ones.
REQ-017 SHALL keep hi_cnt: loads 1 on the rise cycle, then increments on cycles with synchronized level 1, saturating at all-ones.
REQ-018 On a rise in state MEAS or LOCK: period_out<=per_cnt, high_out<=hi_cnt, meas_valid=1 for one cycle.
REQ-019 States: IDLE, MEAS, LOCK, STALL (encoding in package).
REQ-020 IDLE: on first rise go to MEAS and start counters; no meas_valid.
REQ-021 MEAS: each reported period within exp_period±tol (inclusive) increments match_cnt, else clears it; on reaching LOCK_N go to LOCK.
REQ-022 LOCK: any out-of-tolerance period clears match_cnt and returns to MEAS in the same cycle meas_valid pulses.
REQ-023 MEAS or LOCK: per_cnt reaching TIMEOUT without a rise SHALL enter STALL and clear match_cnt.
REQ-024 STALL: next rise goes to MEAS and restarts counters; no meas_valid on that rise, because the period is incomplete.
REQ-025 Tolerance compare SHALL be computed at CNT_W+1 bits so that exp_period+tol cannot wrap; exp_period<tol clamps the lower bound to 0.
REQ-026 A saturated per_cnt SHALL be reported as all-ones and counts as out of tolerance.

Reset
REQ-027 rst_n low SHALL asynchronously set state=IDLE, sync flops, edge register, per_cnt, hi_cnt and match_cnt to 0.
REQ-028 During reset, period_out=0, high_out=0, meas_valid=0, lock=0, stall=0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial measurement; after release the first rise is treated as in IDLE.

Structure
REQ-030 SHALL place the state enum typedef and default parameter constants in package clk_mon_pkg.
REQ-031 SHALL implement the synchronizer plus rise detector as sub-module sync_rise (ports clk, rst_n, d, level, rise).

Verification
REQ-032 clk_in = divide-by-3 50% clock (1.5 clk high), exp_period=3, tol=0 -> period_out=3 on every meas_valid, high_out in {1,2}, lock rises after the 5th rise (first rise + 4 periods).
REQ-033 clk_in period 6, high 3, exp_period=6, tol=0 -> period_out=6, high_out=3, lock=1 after 4 reports; change to period 8 -> next meas_valid period_out=8, lock drops same cycle.
REQ-034 clk_in held low after lock, TIMEOUT=1000 -> stall=1 when per_cnt reaches 1000, lock=0; resume -> first rise gives no meas_valid, second rise reports.
REQ-035 rst_n pulsed low mid-period -> all outputs 0 immediately; first post-reset rise gives no meas_valid.
REQ-036 exp_period=0xFFFF, tol=0x0010, CNT_W=16 -> no compare wrap; a saturated period reports 0xFFFF and never locks.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMeas  = 2'd1,
    StLock  = 2'd2,
    StStall = 2'd3
  } state_e;

  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTimeout = 1000;
  localparam int unsigned DefLockN   = 4;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module sync_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign level = s2_q;
  assign rise  = s2_q & ~prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of an asynchronous divided clock and tracks lock/stall.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned LOCK_N  = DefLockN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] tol,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             lock,
  output logic             stall
);

  localparam int unsigned      MatchW  = $clog2(LOCK_N + 1);
  localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_N);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e            state_q;
  logic [CNT_W-1:0]  per_cnt_q, hi_cnt_q;
  logic [MatchW-1:0] match_cnt_q;
  logic              level, rise;

  logic [CNT_W:0]    hi_bound, lo_bound, per_ext;
  logic              in_tol;
  logic [32:0]       per_next_w;
  logic              timeout_hit;

  sync_rise u_sync_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_in),
    .level (level),
    .rise  (rise)
  );

  // One extra bit so exp_period + tol cannot wrap; a saturated count is never in tolerance.
  always_comb begin
    hi_bound = {1'b0, exp_period} + {1'b0, tol};
    lo_bound = (exp_period >= tol) ? {1'b0, exp_period - tol} : '0;
    per_ext  = {1'b0, per_cnt_q};
    in_tol   = (per_cnt_q != CntMax) && (per_ext >= lo_bound) && (per_ext <= hi_bound);
  end

  // Stall is declared on the cycle the period counter reaches TIMEOUT.
  assign per_next_w  = 33'(per_cnt_q) + 33'd1;
  assign timeout_hit = (per_cnt_q != CntMax) && (per_next_w >= 33'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      match_cnt_q <= '0;
      period_out  <= '0;
      high_out    <= '0;
      meas_valid  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      if (rise) begin
        per_cnt_q <= CNT_W'(1);
        hi_cnt_q  <= CNT_W'(1);
      end else begin
        if (per_cnt_q != CntMax) per_cnt_q <= per_cnt_q + CNT_W'(1);
        if (level && (hi_cnt_q != CntMax)) hi_cnt_q <= hi_cnt_q + CNT_W'(1);
      end

      case (state_q)
        StIdle, StStall: begin
          match_cnt_q <= '0;
          if (rise) state_q <= StMeas;
        end
        StMeas: begin
          if (rise) begin
            period_out <= per_cnt_q;
            high_out   <= hi_cnt_q;
            meas_valid <= 1'b1;
            if (in_tol) begin
              if ((match_cnt_q + MatchW'(1)) >= LockCnt) begin
                match_cnt_q <= LockCnt;
                state_q     <= StLock;
              end else begin
                match_cnt_q <= match_cnt_q + MatchW'(1);
              end
            end else begin
              match_cnt_q <= '0;
            end
          end else if (timeout_hit) begin
            match_cnt_q <= '0;
            state_q     <= StStall;
          end
        end
        StLock: begin
          if (rise) begin
            period_out <= per_cnt_q;
            high_out   <= hi_cnt_q;
            meas_valid <= 1'b1;
            if (!in_tol) begin
              match_cnt_q <= '0;
              state_q     <= StMeas;
            end
          end else if (timeout_hit) begin
            match_cnt_q <= '0;
            state_q     <= StStall;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lock  = (state_q == StLock);
  assign stall = (state_q == StStall);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench: stimulus pushes expected reports, monitors pop them on meas_valid.
module tb_clk_div_monitor;

  localparam int CW  = 16;
  localparam int CW2 = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rst2_n = 1'b0;
  logic           clk_in = 1'b0;
  logic           clk_in2 = 1'b0;
  logic [CW-1:0]  exp_period, tol, period_out, high_out;
  logic           meas_valid, lock, stall;
  logic [CW2-1:0] exp2, tol2, per2, hi2;
  logic           mv2, lock2, stall2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int per;
    int hi;
    int lk;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .CNT_W   (CW),
    .TIMEOUT (1000),
    .LOCK_N  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .exp_period (exp_period),
    .tol        (tol),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .lock       (lock),
    .stall      (stall)
  );

  // Narrow instance makes counter saturation and the wide tolerance compare reachable.
  clk_div_monitor #(
    .CNT_W   (CW2),
    .TIMEOUT (1000),
    .LOCK_N  (4)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst2_n),
    .clk_in     (clk_in2),
    .exp_period (exp2),
    .tol        (tol2),
    .period_out (per2),
    .high_out   (hi2),
    .meas_valid (mv2),
    .lock       (lock2),
    .stall      (stall2)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push1(input int per, input int hi, input int lk);
    exp_t e;
    e.per = per; e.hi = hi; e.lk = lk;
    q1.push_back(e);
  endtask

  task automatic push2(input int per, input int hi, input int lk);
    exp_t e;
    e.per = per; e.hi = hi; e.lk = lk;
    q2.push_back(e);
  endtask

  // One clk_in pulse; durations in half clk cycles.
  task automatic pulse(input bit which, input int hi_h, input int lo_h);
    if (which) clk_in2 = 1'b1; else clk_in = 1'b1;
    #(5 * hi_h);
    if (which) clk_in2 = 1'b0; else clk_in = 1'b0;
    #(5 * lo_h);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (meas_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected_valid: got period %0d, expected no report", period_out);
      end else begin
        e1 = q1.pop_front();
        check("main_period", int'(period_out), e1.per);
        check("main_high", int'(high_out), e1.hi);
        check("main_lock", int'(lock), e1.lk);
      end
    end
  end

  always @(negedge clk) begin
    if (mv2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sat_unexpected_valid: got period %0d, expected no report", per2);
      end else begin
        e2 = q2.pop_front();
        check("sat_period", int'(per2), e2.per);
        check("sat_high", int'(hi2), e2.hi);
        check("sat_lock", int'(lock2), e2.lk);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_period = 16'd3;
    tol        = 16'd0;
    exp2       = 8'hFF;
    tol2       = 8'h10;
    wait_cycles(3);
    check("reset_period", int'(period_out), 0);
    check("reset_high", int'(high_out), 0);
    check("reset_valid", int'(meas_valid), 0);
    check("reset_lock", int'(lock), 0);
    check("reset_stall", int'(stall), 0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    // Divide-by-3: lock after first rise plus four matching periods.
    push1(3, 1, 0); push1(3, 1, 0); push1(3, 1, 0); push1(3, 1, 1); push1(3, 1, 1);
    @(posedge clk); #1;
    repeat (6) pulse(1'b0, 3, 3);
    wait_cycles(10);
    check("a_drain", q1.size(), 0);
    check("a_lock", int'(lock), 1);

    rst_n = 1'b0;
    wait_cycles(2);
    exp_period = 16'd6;
    rst_n = 1'b1;

    // Period 6 locks, one period-8 breaks lock, then relock.
    push1(6, 3, 0); push1(6, 3, 0); push1(6, 3, 0); push1(6, 3, 1); push1(6, 3, 1);
    push1(6, 3, 1); push1(8, 4, 0);
    push1(6, 3, 0); push1(6, 3, 0); push1(6, 3, 0); push1(6, 3, 1);
    @(posedge clk); #1;
    repeat (6) pulse(1'b0, 6, 6);
    pulse(1'b0, 8, 8);
    repeat (5) pulse(1'b0, 6, 6);
    n = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      if (stall) begin
        n = i;
        break;
      end
    end
    check("b_drain", q1.size(), 0);
    check("stall_latency", n, 996);
    check("stall_flag", int'(stall), 1);
    check("stall_lock", int'(lock), 0);

    // Resume from stall: first rise silent, second reports.
    push1(6, 3, 0);
    @(posedge clk); #1;
    repeat (2) pulse(1'b0, 6, 6);
    wait_cycles(5);
    check("resume_drain", q1.size(), 0);
    check("resume_stall", int'(stall), 0);
    check("resume_period", int'(period_out), 6);

    // Reset mid-pulse clears outputs immediately and discards the partial period.
    clk_in = 1'b1;
    #20;
    rst_n = 1'b0;
    #1;
    check("midrst_period", int'(period_out), 0);
    check("midrst_high", int'(high_out), 0);
    check("midrst_valid", int'(meas_valid), 0);
    check("midrst_lock", int'(lock), 0);
    check("midrst_stall", int'(stall), 0);
    clk_in = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    push1(6, 3, 0);
    @(posedge clk); #1;
    repeat (2) pulse(1'b0, 6, 6);
    wait_cycles(5);
    check("postrst_drain", q1.size(), 0);

    // 8-bit instance: 240 lies inside 0xFF +/- 0x10 only without wrap; 420 saturates to 255.
    push2(240, 120, 0); push2(240, 120, 0); push2(240, 120, 0); push2(240, 120, 1);
    push2(240, 120, 1); push2(255, 120, 0); push2(240, 120, 0);
    @(posedge clk); #1;
    repeat (5) pulse(1'b1, 240, 240);
    pulse(1'b1, 240, 600);
    repeat (2) pulse(1'b1, 240, 240);
    wait_cycles(10);
    check("sat_drain", q2.size(), 0);
    check("sat_final_lock", int'(lock2), 0);
    check("sat_final_stall", int'(stall2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
